// File: rtl/div_sqrt_iter_ctrl.sv
// rtl/div_sqrt_iter_ctrl.sv - sequencing controller for the iterative div/sqrt datapath
module div_sqrt_iter_ctrl #(
  parameter int C_ITER_DIV  = 27,
  parameter int C_ITER_SQRT = 26,
  parameter int C_CNT_W     = 5
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic               Div_start_SI,
  input  logic               Sqrt_start_SI,
  input  logic               Kill_SI,
  input  logic [C_CNT_W-1:0] Precision_ctl_SI,
  output logic               Ready_SO,
  output logic               Start_SO,
  output logic               Op_div_SO,
  output logic               Load_SO,
  output logic               Iter_en_SO,
  output logic [C_CNT_W-1:0] Iter_cnt_DO,
  output logic               Last_iter_SO,
  output logic               Round_SO,
  output logic               Done_SO
);

  localparam logic [C_CNT_W-1:0] FULL_DIV  = C_CNT_W'(C_ITER_DIV);
  localparam logic [C_CNT_W-1:0] FULL_SQRT = C_CNT_W'(C_ITER_SQRT);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, ROUND} state_t;

  state_t             state, state_nxt;
  logic [C_CNT_W-1:0] cnt, n_q, n_acc, full;
  logic               op_div, done, accept, last, abort;

  // Divide has priority when both requests arrive together.
  assign full   = Div_start_SI ? FULL_DIV : FULL_SQRT;
  assign n_acc  = (Precision_ctl_SI == '0 || Precision_ctl_SI > full) ? full : Precision_ctl_SI;
  assign accept = (state == IDLE) && !Kill_SI && (Div_start_SI || Sqrt_start_SI);
  assign abort  = (state != IDLE) && Kill_SI;
  assign last   = (state == ITER) && (cnt == n_q - 1'b1);

  always_comb begin
    state_nxt    = state;
    Load_SO      = 1'b0;
    Iter_en_SO   = 1'b0;
    Last_iter_SO = 1'b0;
    Round_SO     = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = LOAD;
      LOAD: begin
        Load_SO   = 1'b1;
        state_nxt = ITER;
      end
      ITER: begin
        Iter_en_SO   = 1'b1;
        Last_iter_SO = last;
        if (last) state_nxt = ROUND;
      end
      ROUND: begin
        Round_SO  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state  <= IDLE;
      cnt    <= '0;
      n_q    <= '0;
      op_div <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      // A kill during ROUND cancels the result as well.
      done  <= (state == ROUND) && !Kill_SI;
      if (accept) begin
        op_div <= Div_start_SI;
        n_q    <= n_acc;
      end
      if (abort || accept || state == LOAD)
        cnt <= '0;
      else if (state == ITER && !last)
        cnt <= cnt + 1'b1;
    end
  end

  assign Ready_SO    = (state == IDLE);
  assign Start_SO    = accept;
  assign Op_div_SO   = op_div;
  assign Iter_cnt_DO = cnt;
  assign Done_SO     = done;

endmodule

// File: tb/tb_div_sqrt_iter_ctrl.sv
// tb/tb_div_sqrt_iter_ctrl.sv - directed and randomized checks of div_sqrt_iter_ctrl against a timeline model
module tb_div_sqrt_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, div, sqrt, kill;
  logic [4:0] prec;
  logic       ready, start, op_div, load, iter_en, last, round, done;
  logic [4:0] cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: an accepted operation is a timeline measured from its accept cycle.
  bit m_active = 0;
  bit m_op = 0;
  int m_tacc = 0;
  int m_n = 0;
  int m_hold = 0;

  always #5 clk = ~clk;

  div_sqrt_iter_ctrl dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Div_start_SI(div), .Sqrt_start_SI(sqrt), .Kill_SI(kill),
    .Precision_ctl_SI(prec),
    .Ready_SO(ready), .Start_SO(start), .Op_div_SO(op_div),
    .Load_SO(load), .Iter_en_SO(iter_en), .Iter_cnt_DO(cnt),
    .Last_iter_SO(last), .Round_SO(round), .Done_SO(done)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h expected=%h (rdy,start,op,load,iter,cnt5,last,round,done)",
               tag, cyc, act, exp);
    end
  endtask

  task automatic step(input string tag, input bit d, input bit s, input bit k, input int p);
    int dd, f, cnt_e;
    bit ready_e, start_e, load_e, iter_e, last_e, round_e, done_e;
    logic [15:0] a, e;
    div = d; sqrt = s; kill = k; prec = p[4:0];
    @(negedge clk);
    done_e = 0;
    if (m_active && cyc - m_tacc == m_n + 3) begin
      m_active = 0;
      done_e   = 1;
      m_hold   = m_n - 1;
    end
    dd      = cyc - m_tacc;
    ready_e = !m_active;
    start_e = ready_e && !k && (d || s);
    load_e  = m_active && dd == 1;
    iter_e  = m_active && dd >= 2 && dd <= m_n + 1;
    last_e  = m_active && dd == m_n + 1;
    round_e = m_active && dd == m_n + 2;
    cnt_e   = iter_e ? dd - 2 : (round_e ? m_n - 1 : m_hold);
    if (load_e) cnt_e = 0;
    e = {3'b0, ready_e, start_e, m_op, load_e, iter_e, 5'(cnt_e), last_e, round_e, done_e};
    a = {3'b0, ready, start, op_div, load, iter_en, (load_e ? 5'd0 : cnt), last, round, done};
    chk(tag, a, e);
    if (m_active && k) begin
      m_active = 0;
      m_hold   = 0;
    end
    if (start_e) begin
      m_active = 1;
      m_tacc   = cyc;
      m_op     = d;
      f        = d ? 27 : 26;
      m_n      = (p == 0 || p > f) ? f : p;
      m_hold   = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input bit d, input bit s, input bit k, input int p, input int n);
    for (int i = 0; i < n; i++) step(tag, d, s, k, p);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    m_active = 0; m_op = 0; m_hold = 0;
    run("reset", 0, 0, 0, 0, 2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; div = 0; sqrt = 0; kill = 0; prec = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse();
    run("idle0", 0, 0, 0, 0, 3);
    run("div_full", 1, 0, 0, 0, 1);   run("div_full", 0, 0, 0, 0, 32);
    run("sqrt_full", 0, 1, 0, 0, 1);  run("sqrt_full", 0, 0, 0, 0, 31);
    run("div_p8", 1, 0, 0, 8, 1);     run("div_p8", 0, 0, 0, 0, 12);
    run("div_p31", 1, 0, 0, 31, 1);   run("div_p31", 0, 0, 0, 0, 32);
    run("both", 1, 1, 0, 0, 1);       run("both", 0, 0, 0, 0, 9);
    run("busy_sqrt", 0, 1, 0, 5, 1);  run("both", 0, 0, 0, 0, 5);
    run("kill_iter", 0, 0, 1, 0, 1);  run("kill_iter", 0, 0, 0, 0, 3);
    run("kill_idle", 1, 0, 1, 0, 1);  run("kill_idle", 0, 0, 0, 0, 2);
    run("b2b", 1, 0, 0, 0, 31);       run("b2b", 0, 0, 0, 0, 32);
    run("div_p1", 1, 0, 0, 1, 1);     run("div_p1", 0, 0, 0, 0, 5);
    run("kill_round", 0, 1, 0, 1, 1); run("kill_round", 0, 0, 0, 0, 2);
    run("kill_round", 0, 0, 1, 0, 1); run("kill_round", 0, 0, 0, 0, 3);
    run("rst_mid", 1, 0, 0, 0, 1);    run("rst_mid", 0, 0, 0, 0, 10);
    reset_pulse();
    run("after_rst", 1, 0, 0, 0, 1);  run("after_rst", 0, 0, 0, 0, 32);
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 6);
      step("random", $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0, p);
      if (i == 1500) reset_pulse();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_sqrt_iter_ctrl.md
Name: div_sqrt_iter_ctrl

Overview:
- Sequencing controller for the iterative div/sqrt datapath.
- Accepts divide/square-root start requests and gates them into a single start pulse for the operand preprocess stage.
- Drives the iteration unit through load, iterate and round phases, then reports completion.
- Sits between the core-side issue logic and the preprocess/iteration/normalize-round blocks.

Parameters:
- C_ITER_DIV, 27, full-precision radix-2 divide iteration count.
- C_ITER_SQRT, 26, full-precision square-root iteration count.
- C_CNT_W, 5, width of iteration counter and precision control.

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- Div_start_SI  in  1  divide request.
- Sqrt_start_SI  in  1  square-root request.
- Kill_SI  in  1  abort current operation.
- Precision_ctl_SI  in  C_CNT_W  requested iteration count; 0 means full precision.
- Ready_SO  out  1  controller idle, request will be accepted.
- Start_SO  out  1  accepted-start pulse to preprocess; combinational.
- Op_div_SO  out  1  latched operation type: 1 = divide, 0 = sqrt.
- Load_SO  out  1  iteration unit loads normalized operands.
- Iter_en_SO  out  1  iteration step enable.
- Iter_cnt_DO  out  C_CNT_W  current iteration index.
- Last_iter_SO  out  1  final iteration cycle.
- Round_SO  out  1  normalize/round cycle.
- Done_SO  out  1  result valid pulse; registered.

Behaviour:
- States: IDLE, LOAD, ITER, ROUND. Reset state IDLE.
- All registered outputs reset to 0 and Iter_cnt_DO to 0. Ready_SO is 1 as soon as reset deasserts.
- Reset assertion mid-operation returns to IDLE immediately; no Done_SO is produced.
- Ready_SO = (state == IDLE). It is combinational from state.

Request acceptance:
- A request is accepted when Ready_SO & ~Kill_SI & (Div_start_SI | Sqrt_start_SI).
- Start_SO = accept, in the same cycle.
- Div_start_SI and Sqrt_start_SI high together: divide wins, sqrt is dropped, Op_div_SO = 1.
- Requests while not IDLE are ignored: Start_SO stays 0 and no state changes.
- On accept, latch Op_div_SO and effective count N.
  - Full value F = C_ITER_DIV for divide, C_ITER_SQRT for sqrt.
  - N = F if Precision_ctl_SI == 0 or Precision_ctl_SI > F; otherwise N = Precision_ctl_SI.
- Next state after accept: LOAD.

Per-state sequencing (accept at cycle t):
- LOAD, cycle t+1: Load_SO = 1; counter cleared to 0; next state ITER.
- ITER, cycles t+2 .. t+1+N: Iter_en_SO = 1; Iter_cnt_DO runs 0..N-1, incrementing each cycle.
  - Last_iter_SO = 1 when Iter_cnt_DO == N-1; next state ROUND.
  - N = 1 is legal: exactly one ITER cycle.
- ROUND, cycle t+2+N: Round_SO = 1; next state IDLE.
- Done_SO: 1 for exactly one cycle at t+3+N.
  - Ready_SO is also 1 in that cycle, so a new request accepted there gives back-to-back operation.
  - Done_SO then coincides with Start_SO of the next operation.

Kill:
- Kill_SI in any non-IDLE state: next state IDLE, counter cleared, no Done_SO.
- Kill_SI in IDLE blocks acceptance in that cycle.
- Kill_SI in the Done_SO cycle does not suppress Done_SO (the operation already completed).

Latching and counter:
- Op_div_SO and N are held stable from the accept cycle until the next accept; request inputs are not re-sampled while busy.
- Iter_cnt_DO is held at its last value in ROUND and IDLE, and cleared in LOAD.
- The counter never wraps because N ≤ 2^C_CNT_W - 1 is guaranteed by the clamp.

Test Plan:
- Divide, Precision 0, Div_start_SI pulse at cycle 10 -> Start_SO@10, Load_SO@11, Iter_en_SO@12..38, Last_iter_SO@38 with cnt=26, Round_SO@39, Done_SO@40, Op_div_SO=1.
- Sqrt, Precision 0, start@10 -> Iter_en_SO@12..37, Done_SO@39, Op_div_SO=0; Precision 8 divide start@10 -> Last_iter_SO@19 cnt=7, Done_SO@21; Precision 31 clamps to 27, Done_SO@40.
- Div_start_SI and Sqrt_start_SI both high @10 -> single Start_SO, Op_div_SO=1, Done_SO@40; Sqrt_start_SI pulsed @20 while busy -> Start_SO=0, no effect.
- Kill_SI @20 during ITER -> IDLE and Ready_SO=1 @21, no Done_SO; Kill_SI with Div_start_SI @30 in IDLE -> Start_SO=0.
- Back-to-back: second divide request held high @40 (Done_SO cycle) -> Start_SO@40, Done_SO@70.
- Rst_RBI low @25 mid-ITER -> all outputs 0 and Ready_SO=1 after release, no Done_SO; a fresh start then gives nominal latency.
